// File: rtl/vm_pkg.sv
// Shared vending-machine definitions used by the deposit path, the
// withdrawal path and the machine-balance register.
//   MONEY_W      : width of every money bus
//   COIN_*       : coin_type encodings on the coin slot
//   VAL_*        : face value of each legal coin
//   vm_state_t   : session state shared by the money paths
package vm_pkg;

  localparam int MONEY_W = 4;

  localparam logic [1:0] COIN_ONE  = 2'b00;
  localparam logic [1:0] COIN_TWO  = 2'b01;
  localparam logic [1:0] COIN_FIVE = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  localparam logic [MONEY_W-1:0] VAL_ONE  = 4'd1;
  localparam logic [MONEY_W-1:0] VAL_TWO  = 4'd2;
  localparam logic [MONEY_W-1:0] VAL_FIVE = 4'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2,
    REFUND  = 2'd3
  } vm_state_t;

  // COMMIT and REFUND are the single-cycle hand-off states.
  function automatic logic is_busy(input vm_state_t s);
    return (s == COMMIT) || (s == REFUND);
  endfunction

endpackage

// File: rtl/coin_decoder.sv
// Combinational coin decoder.
//   coin_type : 2-bit coin slot code
//   value     : face value of the coin (0 for an illegal code)
//   legal     : 1 when coin_type is a recognised coin
module coin_decoder
  import vm_pkg::*;
(
  input  logic [1:0]         coin_type,
  output logic [MONEY_W-1:0] value,
  output logic               legal
);

  always_comb begin
    value = '0;
    legal = 1'b1;
    case (coin_type)
      COIN_ONE:  value = VAL_ONE;
      COIN_TWO:  value = VAL_TWO;
      COIN_FIVE: value = VAL_FIVE;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/customer_deposit.sv
// Customer deposit path: collects coins into a session credit and either
// commits the credit into the machine balance or refunds it (cancel,
// balance overflow or inactivity timeout).
//   clk, rst              : clock, asynchronous active-high reset
//   coin_valid, coin_type : coin slot
//   commit, cancel        : customer buttons (cancel beats commit beats coin)
//   machine_money         : current machine balance, sampled on commit
//   updated_machine_money : new balance, valid with money_update strobe
//   credit                : current session credit
//   refund_valid/amount   : refund strobe and amount
//   red_light             : one-cycle error pulse
//   busy                  : high during the COMMIT/REFUND hand-off cycle
module customer_deposit
  import vm_pkg::*;
#(
  parameter int MAX_CREDIT = 15,
  parameter int TIMEOUT    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       commit,
  input  logic       cancel,
  input  logic [3:0] machine_money,
  output logic [3:0] updated_machine_money,
  output logic       money_update,
  output logic [3:0] credit,
  output logic       refund_valid,
  output logic [3:0] refund_amount,
  output logic       red_light,
  output logic       busy
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [MONEY_W:0]   CREDIT_CAP = (MONEY_W + 1)'(MAX_CREDIT);

  vm_state_t          state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [MONEY_W-1:0] credit_n, upd_n, ra_n;
  logic               mu_n, rv_n, red_n;

  logic [MONEY_W-1:0] coin_value;
  logic               coin_legal;
  logic [MONEY_W:0]   coin_sum, bal_sum;
  logic               coin_ok;

  coin_decoder u_dec (
    .coin_type (coin_type),
    .value     (coin_value),
    .legal     (coin_legal)
  );

  assign coin_sum = {1'b0, credit} + {1'b0, coin_value};
  assign bal_sum  = {1'b0, machine_money} + {1'b0, credit};
  assign coin_ok  = coin_valid && coin_legal && (coin_sum <= CREDIT_CAP);

  always_comb begin
    state_n  = state;
    credit_n = credit;
    cnt_n    = cnt;
    upd_n    = '0;
    mu_n     = 1'b0;
    rv_n     = 1'b0;
    ra_n     = '0;
    red_n    = 1'b0;
    case (state)
      IDLE: begin
        if (cancel) begin
          red_n = coin_valid;
        end else if (commit) begin
          red_n = 1'b1;
        end else if (coin_ok) begin
          credit_n = coin_sum[MONEY_W-1:0];
          cnt_n    = '0;
          state_n  = COLLECT;
        end else begin
          red_n = coin_valid;
        end
      end
      COLLECT: begin
        if (cancel) begin
          red_n   = coin_valid;
          rv_n    = 1'b1;
          ra_n    = credit;
          state_n = REFUND;
        end else if (commit) begin
          // Balance overflow turns the commit into a refund plus error.
          if (bal_sum[MONEY_W]) begin
            red_n   = 1'b1;
            rv_n    = 1'b1;
            ra_n    = credit;
            state_n = REFUND;
          end else begin
            red_n   = coin_valid;
            mu_n    = 1'b1;
            upd_n   = bal_sum[MONEY_W-1:0];
            state_n = COMMIT;
          end
        end else if (coin_ok) begin
          credit_n = coin_sum[MONEY_W-1:0];
          cnt_n    = '0;
        end else begin
          red_n = coin_valid;
          if (cnt == CNT_LAST) begin
            rv_n    = 1'b1;
            ra_n    = credit;
            state_n = REFUND;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      COMMIT, REFUND: begin
        red_n    = coin_valid;
        credit_n = '0;
        cnt_n    = '0;
        state_n  = IDLE;
      end
      default: begin
        credit_n = '0;
        cnt_n    = '0;
        state_n  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      cnt                   <= '0;
      credit                <= '0;
      updated_machine_money <= '0;
      money_update          <= 1'b0;
      refund_valid          <= 1'b0;
      refund_amount         <= '0;
      red_light             <= 1'b0;
      busy                  <= 1'b0;
    end else begin
      state                 <= state_n;
      cnt                   <= cnt_n;
      credit                <= credit_n;
      updated_machine_money <= upd_n;
      money_update          <= mu_n;
      refund_valid          <= rv_n;
      refund_amount         <= ra_n;
      red_light             <= red_n;
      busy                  <= is_busy(state_n);
    end
  end

endmodule
